// File: rtl/ram_stream_reader.sv
// ram_stream_reader: turns (address, length) read commands into sequential
// reads on a simple dual-port RAM read port. Returned words pass through a
// small credit-protected FIFO and leave as a valid/ready stream with a last flag.
//
// Stream handshake: a word transfers on a rising clk edge where m_valid and
// m_ready are both high; while m_valid is high and m_ready low, m_data and
// m_last hold, and m_valid only drops after a transfer. Commands transfer on
// a rising edge with cmd_valid and cmd_ready both high.
module ram_stream_reader #(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = 16,
    parameter int READ_LATENCY = 1,
    parameter int LEN_WIDTH    = 16,
    localparam int ADDR_W      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    output logic [ADDR_W-1:0]    ram_addrb,
    output logic                 ram_enb,
    output logic                 ram_regceb,
    output logic                 ram_rstb,
    input  logic [RAM_WIDTH-1:0] ram_doutb,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    // FIFO sized so a full pipeline of returning reads always has a slot.
    localparam int FD    = READ_LATENCY + 2;
    localparam int CNT_W = $clog2(FD + 1);
    localparam int PTR_W = $clog2(FD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  ram_enb_q, enb_last_q;
    logic [ADDR_W-1:0]     ram_addrb_q;
    logic [READ_LATENCY-1:0] pipe_v_q, pipe_l_q;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic                  ready_q;

    logic [RAM_WIDTH-1:0]  fifo_data [FD];
    logic [FD-1:0]         fifo_last;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  issue, issue_last;
    logic [ADDR_W-1:0]     issue_addr;
    logic                  cmd_hs, push, push_last, pop, credit;
    logic [CNT_W:0]        inflight, occ_after_pop;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_hs    = cmd_valid & ready_q & (state_q == IDLE);
    assign m_valid   = (count_q != '0);
    assign pop       = m_valid & m_ready;
    assign push      = pipe_v_q[READ_LATENCY-1];
    assign push_last = pipe_l_q[READ_LATENCY-1];

    // Count reads issued but not yet in the FIFO (including one landing now).
    always_comb begin
        inflight = (CNT_W + 1)'(ram_enb_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + (CNT_W + 1)'(pipe_v_q[i]);
        end
        occ_after_pop = (CNT_W + 1)'(count_q) - (CNT_W + 1)'(pop);
        credit        = (inflight + occ_after_pop) < (CNT_W + 1)'(FD);
    end

    // Next-state logic: decide whether a read is issued at this edge.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        issue_addr  = cur_addr_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First read goes out with the command so ram_enb rises in cycle 1.
                        issue       = 1'b1;
                        issue_addr  = cmd_addr;
                        issue_last  = (cmd_len == LEN_WIDTH'(1));
                        cur_addr_d  = next_addr(cmd_addr);
                        remaining_d = cmd_len - LEN_WIDTH'(1);
                        state_d     = (cmd_len == LEN_WIDTH'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (credit) begin
                    issue       = 1'b1;
                    issue_addr  = cur_addr_q;
                    issue_last  = (remaining_q == LEN_WIDTH'(1));
                    cur_addr_d  = next_addr(cur_addr_q);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last word leaving means nothing is in flight and the FIFO empties.
                if (pop && fifo_last[rd_ptr_q]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers, read port, return tag pipeline and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            ram_enb_q   <= 1'b0;
            enb_last_q  <= 1'b0;
            ram_addrb_q <= '0;
            pipe_v_q    <= '0;
            pipe_l_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fifo_last   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            ram_enb_q   <= issue;
            enb_last_q  <= issue & issue_last;
            if (issue) begin
                ram_addrb_q <= issue_addr;
            end
            pipe_v_q[0] <= ram_enb_q;
            pipe_l_q[0] <= enb_last_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_l_q[i] <= pipe_l_q[i-1];
            end
            if (push) begin
                fifo_last[wr_ptr_q] <= push_last;
                wr_ptr_q            <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE) | (done_d & (state_q != IDLE));
            ready_q <= (state_d == IDLE);
        end
    end

    // FIFO data storage; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= ram_doutb;
        end
    end

    assign cmd_ready  = ready_q;
    assign ram_addrb  = ram_addrb_q;
    assign ram_enb    = ram_enb_q;
    assign ram_regceb = (READ_LATENCY >= 2) ? pipe_v_q[0] : 1'b0;
    assign ram_rstb   = ~rst_n;
    assign m_data     = m_valid ? fifo_data[rd_ptr_q] : '0;
    assign m_last     = m_valid & fifo_last[rd_ptr_q];
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: instance 0 uses READ_LATENCY=1, instance 1
// uses READ_LATENCY=2, each with its own behavioural RAM.
module tb_ram_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [3:0]  cmd_addr  [2];
    logic [15:0] cmd_len   [2];
    logic [3:0]  ram_addrb [2];
    logic        ram_enb   [2];
    logic        ram_regceb[2];
    logic        ram_rstb  [2];
    logic [31:0] ram_doutb [2];
    logic [31:0] m_data    [2];
    logic        m_valid   [2];
    logic        m_ready   [2];
    logic        m_last    [2];
    logic        busy      [2];
    logic        done      [2];
    logic [1:0]  dbg_state [2];

    ram_stream_reader #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(1), .LEN_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]), .ram_addrb(ram_addrb[0]),
        .ram_enb(ram_enb[0]), .ram_regceb(ram_regceb[0]), .ram_rstb(ram_rstb[0]),
        .ram_doutb(ram_doutb[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_last(m_last[0]), .busy(busy[0]), .done(done[0]),
        .dbg_state(dbg_state[0])
    );

    ram_stream_reader #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(2), .LEN_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]), .ram_addrb(ram_addrb[1]),
        .ram_enb(ram_enb[1]), .ram_regceb(ram_regceb[1]), .ram_rstb(ram_rstb[1]),
        .ram_doutb(ram_doutb[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_last(m_last[1]), .busy(busy[1]), .done(done[1]),
        .dbg_state(dbg_state[1])
    );

    // Behavioural RAMs: 0 is LOW_LATENCY, 1 has an output register on regceb.
    logic [31:0] mem [2][16];
    logic [31:0] lat1;
    always @(posedge clk) begin
        if (ram_rstb[0])     ram_doutb[0] <= '0;
        else if (ram_enb[0]) ram_doutb[0] <= mem[0][ram_addrb[0]];
        if (ram_enb[1])      lat1 <= mem[1][ram_addrb[1]];
        if (ram_rstb[1])        ram_doutb[1] <= '0;
        else if (ram_regceb[1]) ram_doutb[1] <= lat1;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: {dut id, last, data} per expected word, in stream order.
    logic [33:0] exp_q[$];
    int hs_q[$];
    int enb_q[$];
    int addr_q[$];
    int done_q[$];
    int first_mv = -1;
    int last_hs = -1;
    int n_hs = 0;
    bit busy_seen = 0;
    int          out_cnt   [2] = '{0, 0};
    logic        prev_stall[2] = '{0, 0};
    logic [31:0] prev_data [2];
    logic        prev_last [2];
    logic        prev_enb  [2] = '{0, 0};

    // Monitor: expectations from accepted commands, then word-by-word checks.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                out_cnt[d] = 0;
                prev_stall[d] = 0;
                prev_enb[d] = 0;
            end else begin
                if (cmd_valid[d] && cmd_ready[d]) begin
                    hs_q.push_back(cyc);
                    for (int i = 0; i < int'(cmd_len[d]); i++)
                        exp_q.push_back({d[0], (i == int'(cmd_len[d]) - 1),
                                         mem[d][(int'(cmd_addr[d]) + i) % 16]});
                end
                if (ram_enb[d]) begin
                    enb_q.push_back(cyc);
                    addr_q.push_back(int'(ram_addrb[d]));
                    out_cnt[d]++;
                    chk("outstanding_limit", 64'(out_cnt[d] <= d + 3), 64'd1);
                end
                if (d == 1 && (ram_regceb[1] || prev_enb[1]))
                    chk("regceb_follows_enb", 64'(ram_regceb[1]), 64'(prev_enb[1]));
                if (d == 0 && ram_regceb[0])
                    chk("regceb_rl1_zero", 64'(ram_regceb[0]), 64'd0);
                if (prev_stall[d]) begin
                    chk("stall_valid", 64'(m_valid[d]), 64'd1);
                    chk("stall_data", 64'(m_data[d]), 64'(prev_data[d]));
                    chk("stall_last", 64'(m_last[d]), 64'(prev_last[d]));
                end
                if (m_valid[d] && first_mv < 0) first_mv = cyc;
                if (busy[d]) busy_seen = 1;
                if (done[d]) done_q.push_back(cyc);
                if (m_valid[d] && m_ready[d]) begin
                    n_hs++;
                    out_cnt[d]--;
                    if (m_last[d]) last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(m_data[d]), 64'hdead_0000);
                    end else begin
                        logic [33:0] e;
                        e = exp_q.pop_front();
                        chk("word_data", 64'(m_data[d]), 64'(e[31:0]));
                        chk("word_last", 64'(m_last[d]), 64'(e[32]));
                        chk("word_dut", 64'(d), 64'(e[33]));
                    end
                end
                prev_stall[d] = m_valid[d] && !m_ready[d];
                prev_data[d]  = m_data[d];
                prev_last[d]  = m_last[d];
                prev_enb[d]   = ram_enb[d];
            end
        end
    end

    task automatic clear_logs();
        hs_q.delete(); enb_q.delete(); addr_q.delete(); done_q.delete();
        first_mv = -1; last_hs = -1; busy_seen = 0;
    endtask

    // Drive one command; returns #1 into the cycle after the handshake.
    task automatic send(input int d, input logic [3:0] a, input logic [15:0] len);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_valid[d] = 1; cmd_addr[d] = a; cmd_len[d] = len;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready[d]) begin ok = 1; break; end
        end
        if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_valid[d] = 0;
    endtask

    task automatic wait_done(input int d, input int limit, output logic rdy, output logic bsy);
        bit ok;
        ok = 0; rdy = 0; bsy = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done[d]) begin ok = 1; rdy = cmd_ready[d]; bsy = busy[d]; break; end
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", 64'(cmd_ready[0]), 64'd0);
        chk("rst_m_valid", 64'(m_valid[0]), 64'd0);
        chk("rst_m_last", 64'(m_last[0]), 64'd0);
        chk("rst_m_data", 64'(m_data[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);
        chk("rst_enb", 64'(ram_enb[0]), 64'd0);
        chk("rst_regceb", 64'(ram_regceb[1]), 64'd0);
        chk("rst_addrb", 64'(ram_addrb[0]), 64'd0);
        chk("rst_ram_rstb", 64'(ram_rstb[0]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy, bsy;
        int base, hs0, a;
        bit seen;
        rst_n = 0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 0; cmd_addr[d] = 0; cmd_len[d] = 0; m_ready[d] = 1;
        end
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 32'h100 + i;
            mem[1][i] = $urandom;
        end

        // Reset values, then cmd_ready after release.
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(cmd_ready[0]), 64'd1);

        // Basic read: addr 3 len 4 with m_ready high.
        clear_logs();
        send(0, 4'd3, 16'd4);
        wait_done(0, 50, rdy, bsy);
        repeat (3) @(negedge clk);
        chk("t1_enb_count", 64'(enb_q.size()), 64'd4);
        chk("t1_first_enb", 64'(enb_q[0]), 64'(hs_q[0] + 1));
        chk("t1_no_enb_gap", 64'(enb_q[3] - enb_q[0]), 64'd3);
        chk("t1_first_valid", 64'(first_mv), 64'(hs_q[0] + 3));
        chk("t1_done_count", 64'(done_q.size()), 64'd1);
        chk("t1_done_after_last", 64'(done_q[0]), 64'(last_hs + 1));
        chk("t1_ready_in_done", 64'(rdy), 64'd1);
        chk("t1_busy_in_done", 64'(bsy), 64'd1);
        chk("t1_all_words", 64'(exp_q.size()), 64'd0);

        // Address wrap past the top entry.
        clear_logs();
        send(0, 4'd14, 16'd5);
        wait_done(0, 50, rdy, bsy);
        repeat (2) @(negedge clk);
        chk("t2_enb_count", 64'(addr_q.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("t2_addr_seq", 64'(addr_q[i]), 64'((14 + i) % 16));
        chk("t2_all_words", 64'(exp_q.size()), 64'd0);

        // Zero-length command.
        clear_logs();
        send(0, 4'd7, 16'd0);
        chk("t4_done_cycle1", 64'(done[0]), 64'd1);
        chk("t4_ready_cycle1", 64'(cmd_ready[0]), 64'd1);
        repeat (4) @(negedge clk);
        chk("t4_no_enb", 64'(enb_q.size()), 64'd0);
        chk("t4_no_valid", 64'(first_mv), 64'hffff_ffff_ffff_ffff);
        chk("t4_done_once", 64'(done_q.size()), 64'd1);
        chk("t4_busy_never", 64'(busy_seen), 64'd0);

        // Reset after two of eight words, then a fresh command.
        clear_logs();
        base = n_hs;
        send(0, 4'd5, 16'd8);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (n_hs - base >= 2) begin seen = 1; break; end
        end
        chk("t5_two_words", 64'(seen), 64'd1);
        rst_n = 0;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs();
        rst_n = 1;
        @(posedge clk); #1;
        chk("t5_ready_after_release", 64'(cmd_ready[0]), 64'd1);
        clear_logs();
        base = n_hs;
        send(0, 4'd0, 16'd2);
        wait_done(0, 50, rdy, bsy);
        repeat (3) @(negedge clk);
        chk("t5_word_count", 64'(n_hs - base), 64'd2);
        chk("t5_first_valid", 64'(first_mv), 64'(hs_q[0] + 3));
        chk("t5_all_words", 64'(exp_q.size()), 64'd0);

        // cmd_valid held high: second command only in the done cycle.
        clear_logs();
        @(posedge clk); #1;
        cmd_valid[0] = 1; cmd_addr[0] = 4'd2; cmd_len[0] = 16'd3;
        for (int i = 0; i < 10 && hs_q.size() < 1; i++) @(posedge clk);
        #1 cmd_addr[0] = 4'd9; cmd_len[0] = 16'd2;
        for (int i = 0; i < 60 && hs_q.size() < 2; i++) @(posedge clk);
        #1 cmd_valid[0] = 0;
        wait_done(0, 50, rdy, bsy);
        repeat (3) @(negedge clk);
        chk("t6_two_cmds", 64'(hs_q.size()), 64'd2);
        chk("t6_done_count", 64'(done_q.size()), 64'd2);
        chk("t6_second_in_done", 64'(hs_q[1]), 64'(done_q[0]));
        chk("t6_second_enb", 64'(enb_q[3]), 64'(hs_q[1] + 1));
        chk("t6_all_words", 64'(exp_q.size()), 64'd0);

        // READ_LATENCY=2 with random backpressure and a 10-cycle stall.
        clear_logs();
        m_ready[1] = 0;
        a = $urandom_range(0, 15);
        send(1, 4'(a), 16'd12);
        hs0 = hs_q[0];
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (done[1]) begin seen = 1; break; end
            m_ready[1] = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        m_ready[1] = 1;
        chk("t3_done_seen", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_enb_count", 64'(enb_q.size()), 64'd12);
        chk("t3_first_enb", 64'(enb_q[0]), 64'(hs0 + 1));
        chk("t3_first_valid", 64'(first_mv), 64'(hs0 + 4));
        chk("t3_done_after_last", 64'(done_q[0]), 64'(last_hs + 1));
        chk("t3_all_words", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side engine for the simple dual-port RAM. It accepts a read command (start address, word count) and issues sequential reads on the RAM read port (`addrb`/`enb`/`regceb`/`rstb`). It absorbs the configured RAM read latency and presents the returned words as a valid/ready stream with a last flag. It sits between a RAM written by a producer on the port-A clock domain and a downstream consumer running on the port-B clock.

## Interface
Parameters:
- `RAM_WIDTH`, 32, data width; must match the RAM.
- `RAM_DEPTH`, 16, RAM entries; address width `ADDR_W` = number of bits to represent `RAM_DEPTH-1`, minimum 1.
- `READ_LATENCY`, 1, RAM read latency. 1 = RAM built LOW_LATENCY; 2 = RAM built HIGH_PERFORMANCE.
- `LEN_WIDTH`, 16, width of the command word count.

Ports:
- `clk` in 1: single clock; also drives the RAM read clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: engine idle, command can be taken.
- `cmd_addr` in ADDR_W: start address.
- `cmd_len` in LEN_WIDTH: words to read; 0 is legal.
- `ram_addrb` out ADDR_W: RAM read address.
- `ram_enb` out 1: RAM read enable.
- `ram_regceb` out 1: RAM output register enable.
- `ram_rstb` out 1: RAM output reset.
- `ram_doutb` in RAM_WIDTH: RAM read data.
- `m_data` out RAM_WIDTH: stream data.
- `m_valid` out 1: stream data valid.
- `m_ready` in 1: consumer accepts.
- `m_last` out 1: final word of the command.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: `cmd_ready=1`. On `cmd_valid & cmd_ready`, latch `cmd_addr` into `cur_addr` and `cmd_len` into `remaining`.
    - `len==0`: stay in IDLE and pulse `done` next cycle. No RAM access and no stream output.
    - otherwise: go to READ.
  - READ: issue one read per cycle while credit is available. On each issue:
    - drive `ram_enb=1` and `ram_addrb=cur_addr`;
    - increment `cur_addr`, wrapping `RAM_DEPTH-1` -> 0 (not a power-of-2 wrap);
    - decrement `remaining`.
    - After the issue that makes `remaining` 0, go to DRAIN.
  - DRAIN: no issues. When nothing is in flight, the FIFO is empty, and the last word has handshaked, pulse `done` and go to IDLE.
- Output FIFO: depth `FD = READ_LATENCY+2`. Each entry holds data plus a last tag.
- Credit rule: issue allowed only if (in-flight reads + FIFO occupancy after this cycle's pop) < FD. The FIFO never overflows and no returned word is ever dropped.
- Return pipeline: a READ_LATENCY-deep shift register of valid/last tags follows each `ram_enb`.
  - READ_LATENCY=2: `ram_regceb` = stage-1 tag, i.e. high exactly in the cycle after each `ram_enb`.
  - READ_LATENCY=1: `ram_regceb` held 0.
  - When a tag exits the pipeline, `ram_doutb` is written into the FIFO in that cycle.
- `m_last` is set on the word from the final issued address.
- `ram_rstb` = ~`rst_n`, so the RAM output register clears during reset.
- `cmd_valid` is ignored outside IDLE.
- Reset values (all registered): `cmd_ready` 0 while `rst_n` low, 1 from the first cycle after release. `m_valid`, `m_last`, `m_data`, `busy`, `done`, `ram_enb`, `ram_regceb`, `ram_addrb` are all 0.
- Reset mid-operation: state goes to IDLE, and all in-flight tags, FIFO contents and counters are discarded. No stale word may appear after release.

## Timing
- Cycle 0 = command handshake. First `ram_enb` in cycle 1. First `m_valid` in cycle `2+READ_LATENCY`.
- `busy` is high from cycle 1 through the cycle `done` is high.
- Throughput with `m_ready` held 1: one word per cycle and no `ram_enb` gaps after cycle 1.
- `done` fires in the cycle after the `m_last` handshake. `cmd_ready` returns in that same cycle.
- Zero-length command: `done` in cycle 1 and `cmd_ready` in cycle 1; `busy` stays 0.
- Stream rule: while `m_valid & !m_ready`, `m_data` and `m_last` hold stable. `m_valid` never drops without a handshake.
- Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.

## Test plan
- RAM preloaded `mem[i]=0x100+i`, READ_LATENCY=1, command addr 3 len 4, `m_ready=1` -> stream 0x103, 0x104, 0x105, 0x106; `m_last` only on 0x106; first `m_valid` in cycle 3; `done` once, in the cycle after the 0x106 handshake.
- Wrap, RAM_DEPTH=16: command addr 14 len 5 -> `ram_addrb` sequence 14, 15, 0, 1, 2; data 0x10E, 0x10F, 0x100, 0x101, 0x102.
- READ_LATENCY=2, len 12, `m_ready` random with a 10-cycle low stretch -> every word exactly once in order; outstanding reads + FIFO occupancy never exceed 4; `m_data` stable while stalled; `ram_regceb` high exactly one cycle after each `ram_enb`.
- `cmd_len=0` -> no `ram_enb`, no `m_valid`, `done` pulse in cycle 1, `cmd_ready=1` in cycle 1.
- `rst_n` low for 1 cycle after 2 of 8 words delivered -> all outputs 0 during reset; a new command (addr 0, len 2) after release yields exactly 0x100, 0x101.
- `cmd_valid` held high across a len-3 command -> second command accepted only in the `done` cycle; no overlap between the two streams.
